aes_stream_loader: RTL and testbench
====================================

// Module: aes_stream_loader
// PURPOSE
//  Byte-serial front/back end for the 128-bit AES core. Assembles a 16-byte key (optional) and a 16-byte
//  plaintext from a valid/ready byte stream, drives the core's In/Key buses, pulses start and waits for done.
//  It then captures the 128-bit result and streams it out as 16 bytes. One block in flight; no overlap.
// PARAMETERS
//  BLOCK_BYTES  16  bytes per key/data block (fixed by AES-128; other values unsupported)
//  RUN_TIMEOUT  64  max cycles from core_start to core_done before abort (range 2..255)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    synchronous reset, active-high
//  key_load     in   1    sampled on first accepted byte of a frame: 1 = 16 key bytes precede plaintext
//  s_data       in   8    input byte
//  s_valid      in   1    input byte valid
//  s_ready      out  1    loader accepts s_data this cycle
//  core_in      out  128  plaintext to core (byte 0 of frame -> [127:120])
//  core_key     out  128  key to core (key byte 0 -> [127:120])
//  core_start   out  1    one-cycle start pulse
//  core_done    in   1    core result valid pulse
//  core_out     in   128  core result, sampled when core_done=1
//  m_data       out  8    output byte ([127:120] of result first)
//  m_valid      out  1    output byte valid
//  m_ready      in   1    downstream accepts m_data
//  busy         out  1    state != IDLE
//  err_nokey    out  1    sticky: plaintext frame started with no key ever loaded
//  err_timeout  out  1    sticky: core_done not seen within RUN_TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; all outputs 0 except s_ready=1 after the edge; key_reg, data_reg,
//   key_ok, byte counter, timeout counter, both sticky errors cleared. Reset mid-frame aborts with no output.
//  States: IDLE, LOAD_KEY, LOAD_PT, START, RUN, UNLOAD.
//  IDLE: s_ready=1. Byte accepted (s_valid&s_ready) -> if key_load: byte->key_reg MSB, cnt=1, go LOAD_KEY;
//   else if key_ok: byte->data_reg MSB, cnt=1, go LOAD_PT; else set err_nokey, drop byte, stay IDLE.
//  LOAD_KEY: s_ready=1; each accepted byte shifts into key_reg (left shift 8, new byte at [7:0]);
//   on 16th byte set key_ok=1, cnt=0, go LOAD_PT. s_valid=0 stalls indefinitely (no timeout).
//  LOAD_PT: same shifting into data_reg; 16th byte -> START. Byte order: first byte ends in [127:120].
//  START: s_ready=0; core_start=1 for exactly this cycle; tcnt=0; go RUN.
//  RUN: s_ready=0; core_in/core_key held stable. core_done=1 -> capture core_out into data_reg, cnt=0,
//   go UNLOAD. Else tcnt++; tcnt==RUN_TIMEOUT-1 without done -> set err_timeout, go IDLE (no output).
//   core_done outside RUN is ignored.
//  UNLOAD: m_valid=1, m_data=data_reg[127:120]; on m_ready: shift data_reg left 8, cnt++; 16th transfer ->
//   m_valid=0 next cycle, go IDLE. m_data must not change while m_valid&!m_ready.
//  Latency: last input byte accepted at cycle T -> core_start at T+1; first m_valid at (core_done cycle)+1.
//  Key persists across frames; frames with key_load=0 reuse it. core_key/core_in change only in LOAD_*.
//  s_ready and m_valid are never both 1. Errors clear only on rst. Counters: cnt 5 bits, tcnt 8 bits.
// STRUCTURE
//  Package aes_stream_pkg: state enum (IDLE..UNLOAD), BLOCK_BYTES=16, AES_W=128 localparams.
//  One sub-module: aes_byte_shifter (128-bit reg, load-parallel, shift-in-byte, shift-out-byte);
//   instantiated twice (key, data). FSM, counters, timeout in top.
// TESTING (bench uses the AES_128-compatible core model with fixed 10-cycle done latency)
//  1. key_load=1, key 00..0f, pt 00112233445566778899aabbccddeeff -> core_start once; out bytes
//     69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in order; busy drops after 16th m transfer.
//  2. Second frame key_load=0, same pt -> identical ciphertext; exactly 16 s transfers accepted.
//  3. After rst, key_load=0 frame -> err_nokey=1, byte dropped, no core_start, stays IDLE.
//  4. Core model never asserts done -> err_timeout=1 exactly RUN_TIMEOUT cycles after start; no m_valid.
//  5. Random s_valid gaps and m_ready backpressure (50%) -> same ciphertext, m_data stable while stalled.
//  6. rst asserted at byte 7 of LOAD_PT and during UNLOAD byte 3 -> all outputs 0, key_ok=0, s_ready=1 next.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// -----------------------------------------------------------------------------
// aes_stream_pkg
// Shared types and constants for the byte-serial AES-128 stream loader.
//   state_t      : loader FSM states (IDLE .. UNLOAD)
//   BLOCK_BYTES  : bytes per key / plaintext / ciphertext block
//   AES_W        : width of the core In/Key/Out buses
//   CNT_W/TCNT_W : widths of the byte counter and the run timeout counter
//   is_last_byte : true when the byte counter addresses the final byte of a block
// -----------------------------------------------------------------------------
package aes_stream_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned AES_W       = 128;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned TCNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_KEY = 3'd1,
    LOAD_PT  = 3'd2,
    START    = 3'd3,
    RUN      = 3'd4,
    UNLOAD   = 3'd5
  } state_t;

  // The counter holds the number of bytes already moved, so the transfer in
  // flight is the last one when it equals BLOCK_BYTES-1.
  function automatic logic is_last_byte(input logic [CNT_W-1:0] cnt);
    return (cnt == 5'(BLOCK_BYTES - 1));
  endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// -----------------------------------------------------------------------------
// aes_byte_shifter
// 128-bit register that is either loaded in parallel or shifted up by one byte
// with a new byte entering at [7:0]. Shifting in 16 bytes leaves the first byte
// in [127:120]; shifting in zeros walks the register out MSB-byte first.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset, clears the register
//   i_load       parallel load of i_load_data (wins over i_shift)
//   i_load_data  parallel load value
//   i_shift      shift left by 8, i_byte into [7:0]
//   i_byte       byte shifted in
//   o_q          register contents
// -----------------------------------------------------------------------------
module aes_byte_shifter
  import aes_stream_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [AES_W-1:0] i_load_data,
  input  logic             i_shift,
  input  logic [7:0]       i_byte,
  output logic [AES_W-1:0] o_q
);

  logic [AES_W-1:0] r_q;

  // Block register: reset, parallel load, byte shift or hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= {AES_W{1'b0}};
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[AES_W-9:0], i_byte};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/aes_stream_loader.sv
// -----------------------------------------------------------------------------
// aes_stream_loader
// Byte-serial front/back end for a 128-bit AES core. Collects an optional
// 16-byte key and a 16-byte plaintext from a valid/ready byte stream, pulses
// the core start, waits for done (with timeout), then streams the 16 result
// bytes out MSB byte first. One block in flight at a time.
// Ports:
//   i_clk, i_rst       clock / synchronous active-high reset
//   i_key_load         on the first byte of a frame: 1 = key bytes precede plaintext
//   i_s_data/i_s_valid input byte stream; o_s_ready = byte accepted this cycle
//   o_core_in          plaintext to core (frame byte 0 in [127:120])
//   o_core_key         key to core (key byte 0 in [127:120])
//   o_core_start       one-cycle start pulse
//   i_core_done        result valid pulse, i_core_out sampled with it
//   o_m_data/o_m_valid output byte stream, i_m_ready = downstream accepts
//   o_busy             FSM not idle
//   o_err_nokey        sticky: plaintext frame with no key ever loaded
//   o_err_timeout      sticky: core did not finish within RUN_TIMEOUT cycles
// -----------------------------------------------------------------------------
module aes_stream_loader
  import aes_stream_pkg::*;
#(
  parameter int unsigned RUN_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_key_load,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [AES_W-1:0] o_core_in,
  output logic [AES_W-1:0] o_core_key,
  output logic             o_core_start,
  input  logic             i_core_done,
  input  logic [AES_W-1:0] i_core_out,
  output logic [7:0]       o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic             o_busy,
  output logic             o_err_nokey,
  output logic             o_err_timeout
);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_key_ok;
  logic                r_err_nokey;
  logic                r_err_timeout;

  logic                w_s_ready;
  logic                w_m_valid;
  logic                w_core_start;
  logic                w_s_fire;
  logic                w_m_fire;
  logic                w_run_expired;
  logic                w_last;
  logic                w_key_shift;
  logic                w_data_shift;
  logic                w_data_load;
  logic [7:0]          w_data_byte;
  logic [AES_W-1:0]    w_key_q;
  logic [AES_W-1:0]    w_data_q;

  assign w_s_fire      = i_s_valid & w_s_ready;
  assign w_m_fire      = w_m_valid & i_m_ready;
  assign w_last        = is_last_byte(r_cnt);
  // tcnt counts completed RUN cycles; the cycle holding RUN_TIMEOUT-1 is the last chance.
  assign w_run_expired = (r_tcnt == 8'(RUN_TIMEOUT - 32'd1));

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_s_fire && i_key_load) begin
          w_next_state = LOAD_KEY;
        end else if (w_s_fire && r_key_ok) begin
          w_next_state = LOAD_PT;
        end else begin
          // No byte, or a plaintext byte with no key: the byte is dropped.
          w_next_state = IDLE;
        end
      end
      LOAD_KEY: begin
        if (w_s_fire && w_last) begin
          w_next_state = LOAD_PT;
        end else begin
          w_next_state = LOAD_KEY;
        end
      end
      LOAD_PT: begin
        if (w_s_fire && w_last) begin
          w_next_state = START;
        end else begin
          w_next_state = LOAD_PT;
        end
      end
      START: begin
        w_next_state = RUN;
      end
      RUN: begin
        if (i_core_done) begin
          w_next_state = UNLOAD;
        end else if (w_run_expired) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RUN;
        end
      end
      UNLOAD: begin
        if (w_m_fire && w_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = UNLOAD;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM output decode (Moore): handshake flags and start pulse.
  always_comb begin
    w_s_ready    = 1'b0;
    w_m_valid    = 1'b0;
    w_core_start = 1'b0;
    case (r_state)
      IDLE, LOAD_KEY, LOAD_PT: begin
        w_s_ready = 1'b1;
      end
      START: begin
        w_core_start = 1'b1;
      end
      RUN: begin
        w_s_ready = 1'b0;
      end
      UNLOAD: begin
        w_m_valid = 1'b1;
      end
      default: begin
        w_s_ready = 1'b0;
      end
    endcase
  end

  // Datapath strobes for the key and data shifters.
  always_comb begin
    w_key_shift  = 1'b0;
    w_data_shift = 1'b0;
    w_data_load  = 1'b0;
    w_data_byte  = i_s_data;
    case (r_state)
      IDLE: begin
        w_key_shift  = w_s_fire & i_key_load;
        w_data_shift = w_s_fire & ~i_key_load & r_key_ok;
      end
      LOAD_KEY: begin
        w_key_shift = w_s_fire;
      end
      LOAD_PT: begin
        w_data_shift = w_s_fire;
      end
      RUN: begin
        w_data_load = i_core_done;
      end
      UNLOAD: begin
        // Shift zeros in behind the bytes being sent.
        w_data_shift = w_m_fire;
        w_data_byte  = 8'h00;
      end
      default: begin
        w_data_shift = 1'b0;
      end
    endcase
  end

  // Byte counter: bytes moved within the current key / plaintext / result block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s_fire && (i_key_load || r_key_ok)) begin
            r_cnt <= 5'd1;
          end else begin
            r_cnt <= 5'd0;
          end
        end
        LOAD_KEY, LOAD_PT: begin
          if (w_s_fire) begin
            r_cnt <= w_last ? 5'd0 : (r_cnt + 5'd1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        RUN: begin
          r_cnt <= 5'd0;
        end
        UNLOAD: begin
          if (w_m_fire) begin
            r_cnt <= w_last ? 5'd0 : (r_cnt + 5'd1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Run timeout counter: cleared on start, advances each RUN cycle without done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt <= 8'd0;
    end else if (r_state == START) begin
      r_tcnt <= 8'd0;
    end else if ((r_state == RUN) && !i_core_done && !w_run_expired) begin
      r_tcnt <= r_tcnt + 8'd1;
    end else begin
      r_tcnt <= r_tcnt;
    end
  end

  // Key-valid flag and sticky error flags; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_ok      <= 1'b0;
      r_err_nokey   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if ((r_state == LOAD_KEY) && w_s_fire && w_last) begin
        r_key_ok <= 1'b1;
      end else begin
        r_key_ok <= r_key_ok;
      end
      if ((r_state == IDLE) && w_s_fire && !i_key_load && !r_key_ok) begin
        r_err_nokey <= 1'b1;
      end else begin
        r_err_nokey <= r_err_nokey;
      end
      if ((r_state == RUN) && !i_core_done && w_run_expired) begin
        r_err_timeout <= 1'b1;
      end else begin
        r_err_timeout <= r_err_timeout;
      end
    end
  end

  aes_byte_shifter u_key_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (1'b0),
    .i_load_data ({AES_W{1'b0}}),
    .i_shift     (w_key_shift),
    .i_byte      (i_s_data),
    .o_q         (w_key_q)
  );

  // The data register holds the plaintext, then is reused for the result.
  aes_byte_shifter u_data_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_data_load),
    .i_load_data (i_core_out),
    .i_shift     (w_data_shift),
    .i_byte      (w_data_byte),
    .o_q         (w_data_q)
  );

  assign o_s_ready     = w_s_ready;
  assign o_m_valid     = w_m_valid;
  assign o_core_start  = w_core_start;
  assign o_core_in     = w_data_q;
  assign o_core_key    = w_key_q;
  assign o_m_data      = w_data_q[AES_W-1 -: 8];
  assign o_busy        = (r_state != IDLE);
  assign o_err_nokey   = r_err_nokey;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_aes_stream_loader.sv
module tb_aes_stream_loader;

  localparam int RUN_TIMEOUT = 64;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] core_in;
  logic [127:0] core_key;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_out = 128'h0;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         busy;
  logic         err_nokey;
  logic         err_timeout;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_sacc = 0;
  int n_mvalid = 0;
  int n_both = 0;
  bit core_respond = 1'b1;
  int run_cnt = 0;
  logic [127:0] run_res = 128'h0;

  always #5 clk = ~clk;

  aes_stream_loader #(.RUN_TIMEOUT(RUN_TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_load(key_load), .i_s_data(s_data),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .o_core_in(core_in),
    .o_core_key(core_key), .o_core_start(core_start), .i_core_done(core_done),
    .i_core_out(core_out), .o_m_data(m_data), .o_m_valid(m_valid),
    .i_m_ready(m_ready), .o_busy(busy), .o_err_nokey(err_nokey),
    .o_err_timeout(err_timeout)
  );

  // ---------------- AES-128 reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] aes128_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] st, rk;
    logic [31:0]  w0, w1, w2, w3, t;
    logic [7:0]   rcon;
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    rk = key;
    st = pt ^ rk;
    rcon = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
      t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rcon, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rk = {w0, w1, w2, w3};
      rcon = xt(rcon);
      for (int i = 0; i < 16; i++) a[i] = sb(st[127 - 8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
          a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) a[i] = b[i];
      end
      for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = a[i] ^ rk[127 - 8*i -: 8];
    end
    return st;
  endfunction

  // Core model: done pulse 10 cycles after start unless disabled.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      run_cnt <= 10;
      run_res <= aes128_enc(core_in, core_key);
    end else if (run_cnt > 0) begin
      run_cnt <= run_cnt - 1;
      if (run_cnt == 1 && core_respond) begin
        core_done <= 1'b1;
        core_out  <= run_res;
      end
    end
  end

  // Event counters.
  always @(posedge clk) begin
    if (core_start) n_start <= n_start + 1;
    if (s_valid && s_ready) n_sacc <= n_sacc + 1;
    if (m_valid) n_mvalid <= n_mvalid + 1;
    if (m_valid && s_ready) n_both <= n_both + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    budget = 0;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) chk("s_accept_timeout", 128'(budget), 128'(0));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input bit kl, input logic [127:0] key, input logic [127:0] pt, input bit gaps);
    key_load = kl;
    if (kl) for (int i = 0; i < 16; i++) send_byte(key[127 - 8*i -: 8], gaps);
    for (int i = 0; i < 16; i++) send_byte(pt[127 - 8*i -: 8], gaps);
    key_load = 1'b0;
  endtask

  task automatic recv_bytes(input int n, input bit bp, output logic [127:0] got,
                            output bit stable_ok, output bit timed_out);
    int cnt, cyc;
    bit pending;
    logic [7:0] held;
    cnt = 0; cyc = 0; pending = 1'b0; held = 8'h00;
    got = 128'h0; stable_ok = 1'b1;
    while (cnt < n && cyc < 2000) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid) begin
        if (pending && m_data !== held) stable_ok = 1'b0;
        if (m_ready) begin
          got = {got[119:0], m_data};
          cnt++;
          pending = 1'b0;
        end else begin
          pending = 1'b1;
          held = m_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    timed_out = (cnt < n);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] got;
    bit stable_ok, to;
    int s0, a0, m0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags", 128'({s_ready, busy, m_valid, core_start, err_nokey, err_timeout}), 128'(6'b100000));
    chk("reset_core_in", core_in, 128'h0);
    chk("reset_core_key", core_key, 128'h0);

    // 1. Key + plaintext, FIPS-197 vector.
    s0 = n_start;
    send_frame(1'b1, KEY0, PT0, 1'b0);
    chk("t1_start_pulse", 128'(core_start), 128'(1'b1));
    chk("t1_core_key", core_key, KEY0);
    chk("t1_core_in", core_in, PT0);
    recv_bytes(16, 1'b0, got, stable_ok, to);
    chk("t1_recv_timeout", 128'(to), 128'(1'b0));
    chk("t1_ciphertext", got, CT0);
    chk("t1_start_count", 128'(n_start - s0), 128'(1));
    chk("t1_idle_after", 128'({busy, m_valid, s_ready}), 128'(3'b001));

    // 2. Reuse key, same plaintext.
    a0 = n_sacc;
    send_frame(1'b0, 128'h0, PT0, 1'b0);
    chk("t2_s_transfers", 128'(n_sacc - a0), 128'(16));
    chk("t2_run_not_ready", 128'({s_ready, busy}), 128'(2'b01));
    recv_bytes(16, 1'b0, got, stable_ok, to);
    chk("t2_ciphertext", got, CT0);

    // 5. Input gaps and output backpressure.
    send_frame(1'b0, 128'h0, PT0, 1'b1);
    recv_bytes(16, 1'b1, got, stable_ok, to);
    chk("t5_ciphertext", got, CT0);
    chk("t5_m_data_stable", 128'(stable_ok), 128'(1'b1));
    chk("t5_core_key_kept", core_key, KEY0);

    // 6a. Reset at byte 7 of plaintext.
    key_load = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(PT0[127 - 8*i -: 8], 1'b0);
    chk("t6a_busy_before", 128'(busy), 128'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6a_flags", 128'({s_ready, busy, m_valid, core_start, err_nokey, err_timeout}), 128'(6'b100000));
    chk("t6a_regs", {core_in ^ core_key}, 128'h0);
    chk("t6a_key_cleared", core_key, 128'h0);

    // 3. No key after reset: byte dropped, error set.
    s0 = n_start;
    send_byte(8'h5a, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_err_nokey", 128'(err_nokey), 128'(1'b1));
    chk("t3_stay_idle", 128'({busy, s_ready}), 128'(2'b01));
    chk("t3_no_start", 128'(n_start - s0), 128'(0));
    chk("t3_core_in_untouched", core_in, 128'h0);

    // 6b. Reset during unload byte 3.
    send_frame(1'b1, KEY0, PT0, 1'b0);
    recv_bytes(3, 1'b0, got, stable_ok, to);
    chk("t6b_partial", got, 128'(24'h69c4e0));
    chk("t6b_still_unload", 128'(m_valid), 128'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6b_flags", 128'({s_ready, busy, m_valid, core_start, err_nokey, err_timeout}), 128'(6'b100000));
    chk("t6b_key_cleared", core_key, 128'h0);

    // 4. Core never finishes.
    core_respond = 1'b0;
    m0 = n_mvalid;
    send_frame(1'b1, KEY0, PT0, 1'b0);
    chk("t4_start", 128'(core_start), 128'(1'b1));
    repeat (RUN_TIMEOUT) @(negedge clk);
    chk("t4_err_not_yet", 128'({err_timeout, busy}), 128'(2'b01));
    @(negedge clk);
    chk("t4_err_timeout", 128'({err_timeout, busy, s_ready}), 128'(3'b101));
    chk("t4_no_m_valid", 128'(n_mvalid - m0), 128'(0));
    core_respond = 1'b1;
    repeat (12) @(negedge clk);

    // Recovery: key retained, sticky timeout kept.
    send_frame(1'b0, 128'h0, PT0, 1'b1);
    recv_bytes(16, 1'b1, got, stable_ok, to);
    chk("rec_ciphertext", got, CT0);
    chk("rec_err_sticky", 128'(err_timeout), 128'(1'b1));
    chk("never_both_ready_valid", 128'(n_both), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
